// File: rtl/pipe_control.sv
// pipe_control: RV32I main decoder feeding a D->E->M->W control pipeline.
// In: clk, rst_n, InstrD, FlushE, ZeroE/LtE/LtuE. Out: ImmSrcD (D);
// ALUControlE, ALUSrcE, JALRctrlE, PCSrcE, ResultSrcE0 (E); MemWriteM,
// RegWriteM (M); ResultSrcW, RegWriteW, IllegalW (W).
// Option macro TRAP_ILLEGAL_EN: pipelines an illegal-opcode flag to IllegalW.
module pipe_control #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] InstrD,
    input  logic               FlushE,
    input  logic               ZeroE,
    input  logic               LtE,
    input  logic               LtuE,
    output logic [2:0]         ImmSrcD,
    output logic [3:0]         ALUControlE,
    output logic               ALUSrcE,
    output logic               JALRctrlE,
    output logic               PCSrcE,
    output logic               ResultSrcE0,
    output logic               MemWriteM,
    output logic               RegWriteM,
    output logic [1:0]         ResultSrcW,
    output logic               RegWriteW,
    output logic               IllegalW
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    logic [6:0] opcode;
    logic [2:0] fn3;
    logic       fn7_5;

    assign opcode = InstrD[6:0];
    assign fn3    = InstrD[14:12];
    assign fn7_5  = InstrD[30];

    // Only opcode/fn3/fn7[5] are decoded; the rest of the word is ignored.
    logic unused_instr;
    assign unused_instr = ^InstrD;

    // OP-IMM has no subi: bit 30 is immediate data unless it is a shift.
    function automatic logic [3:0] alu_fn(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_reg
    );
        logic [3:0] op;
        op = ALU_ADD;
        unique case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic       dec_reg_write;
    logic       dec_mem_write;
    logic       dec_alu_src;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_jalr;
    logic       dec_illegal;
    logic [1:0] dec_result_src;
    logic [3:0] dec_alu_ctrl;
    logic [2:0] dec_imm_src;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_jalr       = 1'b0;
        dec_illegal    = 1'b0;
        dec_result_src = RES_ALU;
        dec_alu_ctrl   = ALU_ADD;
        dec_imm_src    = IMM_I;
        unique case (1'b1)
            (opcode == OP_R): begin
                dec_reg_write = 1'b1;
                dec_alu_ctrl  = alu_fn(fn3, fn7_5, 1'b1);
            end
            (opcode == OP_I): begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctrl  = alu_fn(fn3, fn7_5, 1'b0);
            end
            (opcode == OP_LD): begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = RES_MEM;
            end
            (opcode == OP_ST): begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm_src   = IMM_S;
            end
            (opcode == OP_BR): begin
                dec_branch   = 1'b1;
                dec_imm_src  = IMM_B;
                dec_alu_ctrl = ALU_SUB;
            end
            (opcode == OP_JAL): begin
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
                dec_imm_src    = IMM_J;
                dec_result_src = RES_PC4;
            end
            (opcode == OP_JALR): begin
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
                dec_jalr       = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = RES_PC4;
            end
            (opcode == OP_LUI): begin
                // rs1 is forced to x0 upstream, so add passes the U-imm.
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm_src   = IMM_U;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign ImmSrcD = dec_imm_src;

    logic       e_reg_write_q, e_reg_write_d;
    logic       e_mem_write_q, e_mem_write_d;
    logic       e_alu_src_q, e_alu_src_d;
    logic       e_branch_q, e_branch_d;
    logic       e_jump_q, e_jump_d;
    logic       e_jalr_q, e_jalr_d;
    logic [1:0] e_result_src_q, e_result_src_d;
    logic [3:0] e_alu_ctrl_q, e_alu_ctrl_d;
    logic [2:0] e_fn3_q, e_fn3_d;

    logic       m_reg_write_q, m_reg_write_d;
    logic       m_mem_write_q, m_mem_write_d;
    logic [1:0] m_result_src_q, m_result_src_d;

    logic       w_reg_write_q, w_reg_write_d;
    logic [1:0] w_result_src_q, w_result_src_d;

    always_comb begin
        e_reg_write_d  = 1'b0;
        e_mem_write_d  = 1'b0;
        e_alu_src_d    = 1'b0;
        e_branch_d     = 1'b0;
        e_jump_d       = 1'b0;
        e_jalr_d       = 1'b0;
        e_result_src_d = 2'b00;
        e_alu_ctrl_d   = 4'b0000;
        e_fn3_d        = 3'b000;
        if (!FlushE) begin
            e_reg_write_d  = dec_reg_write;
            e_mem_write_d  = dec_mem_write;
            e_alu_src_d    = dec_alu_src;
            e_branch_d     = dec_branch;
            e_jump_d       = dec_jump;
            e_jalr_d       = dec_jalr;
            e_result_src_d = dec_result_src;
            e_alu_ctrl_d   = dec_alu_ctrl;
            e_fn3_d        = fn3;
        end
        m_reg_write_d  = e_reg_write_q;
        m_mem_write_d  = e_mem_write_q;
        m_result_src_d = e_result_src_q;
        w_reg_write_d  = m_reg_write_q;
        w_result_src_d = m_result_src_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_reg_write_q  <= 1'b0;
            e_mem_write_q  <= 1'b0;
            e_alu_src_q    <= 1'b0;
            e_branch_q     <= 1'b0;
            e_jump_q       <= 1'b0;
            e_jalr_q       <= 1'b0;
            e_result_src_q <= 2'b00;
            e_alu_ctrl_q   <= 4'b0000;
            e_fn3_q        <= 3'b000;
            m_reg_write_q  <= 1'b0;
            m_mem_write_q  <= 1'b0;
            m_result_src_q <= 2'b00;
            w_reg_write_q  <= 1'b0;
            w_result_src_q <= 2'b00;
        end else begin
            e_reg_write_q  <= e_reg_write_d;
            e_mem_write_q  <= e_mem_write_d;
            e_alu_src_q    <= e_alu_src_d;
            e_branch_q     <= e_branch_d;
            e_jump_q       <= e_jump_d;
            e_jalr_q       <= e_jalr_d;
            e_result_src_q <= e_result_src_d;
            e_alu_ctrl_q   <= e_alu_ctrl_d;
            e_fn3_q        <= e_fn3_d;
            m_reg_write_q  <= m_reg_write_d;
            m_mem_write_q  <= m_mem_write_d;
            m_result_src_q <= m_result_src_d;
            w_reg_write_q  <= w_reg_write_d;
            w_result_src_q <= w_result_src_d;
        end
    end

    logic taken;

    always_comb begin
        taken = 1'b0;
        unique case (e_fn3_q)
            3'b000:  taken = ZeroE;
            3'b001:  taken = !ZeroE;
            3'b100:  taken = LtE;
            3'b101:  taken = !LtE;
            3'b110:  taken = LtuE;
            3'b111:  taken = !LtuE;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE      = e_jump_q | (e_branch_q & taken);
    assign ALUControlE = e_alu_ctrl_q;
    assign ALUSrcE     = e_alu_src_q;
    assign JALRctrlE   = e_jalr_q;
    assign ResultSrcE0 = e_result_src_q[0];
    assign MemWriteM   = m_mem_write_q;
    assign RegWriteM   = m_reg_write_q;
    assign ResultSrcW  = w_result_src_q;
    assign RegWriteW   = w_reg_write_q;

`ifdef TRAP_ILLEGAL_EN
    logic e_ill_q, e_ill_d;
    logic m_ill_q, m_ill_d;
    logic w_ill_q, w_ill_d;

    always_comb begin
        e_ill_d = dec_illegal & ~FlushE;
        m_ill_d = e_ill_q;
        w_ill_d = m_ill_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ill_q <= 1'b0;
            m_ill_q <= 1'b0;
            w_ill_q <= 1'b0;
        end else begin
            e_ill_q <= e_ill_d;
            m_ill_q <= m_ill_d;
            w_ill_q <= w_ill_d;
        end
    end

    assign IllegalW = w_ill_q;
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
    assign IllegalW       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed scoreboard bench for pipe_control.
// Driver queues expected outputs; a monitor pops and compares them.
module tb_pipe_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] InstrD = 32'h0;
    logic        FlushE = 1'b0;
    logic        ZeroE = 1'b0;
    logic        LtE = 1'b0;
    logic        LtuE = 1'b0;
    logic [2:0]  ImmSrcD;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE;
    logic        JALRctrlE;
    logic        PCSrcE;
    logic        ResultSrcE0;
    logic        MemWriteM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcW;
    logic        RegWriteW;
    logic        IllegalW;

    pipe_control #(.D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .FlushE(FlushE),
        .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .ImmSrcD(ImmSrcD),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .JALRctrlE(JALRctrlE), .PCSrcE(PCSrcE),
        .ResultSrcE0(ResultSrcE0), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .ResultSrcW(ResultSrcW),
        .RegWriteW(RegWriteW), .IllegalW(IllegalW)
    );

    always #5 clk = ~clk;

`ifdef TRAP_ILLEGAL_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    typedef enum int {
        S_IMMD, S_ALUC, S_ASRC, S_JALR, S_PCS, S_RS0,
        S_MWM, S_RWM, S_RSW, S_RWW, S_ILLW
    } sig_e;

    typedef struct {
        int         due;
        bit         ph;
        sig_e       s;
        logic [3:0] v;
    } exp_t;

    exp_t q[$];
    int   stamp = 0;
    bit   phase = 1'b0;
    int   checks = 0;
    int   errors = 0;
    event smp;

    function automatic logic [3:0] get(input sig_e s);
        logic [3:0] a;
        a = 4'h0;
        case (s)
            S_IMMD: a = {1'b0, ImmSrcD};
            S_ALUC: a = ALUControlE;
            S_ASRC: a = {3'b0, ALUSrcE};
            S_JALR: a = {3'b0, JALRctrlE};
            S_PCS:  a = {3'b0, PCSrcE};
            S_RS0:  a = {3'b0, ResultSrcE0};
            S_MWM:  a = {3'b0, MemWriteM};
            S_RWM:  a = {3'b0, RegWriteM};
            S_RSW:  a = {2'b0, ResultSrcW};
            S_RWW:  a = {3'b0, RegWriteW};
            S_ILLW: a = {3'b0, IllegalW};
            default: a = 4'hx;
        endcase
        return a;
    endfunction

    initial begin
        forever begin
            @(smp);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].due == stamp && q[i].ph == phase) begin
                    logic [3:0] act;
                    act = get(q[i].s);
                    checks++;
                    if (act !== q[i].v) begin
                        errors++;
                        $display("FAIL %s stamp %0d ph %0d got %0h want %0h",
                                 q[i].s.name(), stamp, q[i].ph,
                                 act, q[i].v);
                    end
                    q.delete(i);
                end
            end
        end
    end

    function automatic void exp_at(input int rel, input bit ph,
                                   input sig_e s, input logic [3:0] v);
        exp_t e;
        e.due = stamp + rel;
        e.ph  = ph;
        e.s   = s;
        e.v   = v;
        q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        stamp++;
        phase = 1'b0;
        ->smp;
        #1;
    endtask

    task automatic settle();
        #1;
        phase = 1'b1;
        ->smp;
        #1;
    endtask

    task automatic probe(input sig_e s, input logic [3:0] v);
        exp_at(0, 1'b1, s, v);
        settle();
    endtask

    task automatic flags(input logic z, input logic lt, input logic ltu);
        ZeroE = z;
        LtE   = lt;
        LtuE  = ltu;
    endtask

    // depth: 1 = E checks only, 2 = E+M, 3 = E+M+W.
    task automatic issue(
        input logic [31:0] ins, input logic fl, input int depth,
        input logic [2:0] imm, input logic [3:0] aluc,
        input logic asrc, input logic pcs, input logic jr,
        input logic rs0, input logic mw, input logic rw,
        input logic [1:0] rsw, input logic ill
    );
        InstrD = ins;
        FlushE = fl;
        exp_at(1, 1'b0, S_IMMD, {1'b0, imm});
        exp_at(1, 1'b0, S_ALUC, aluc);
        exp_at(1, 1'b0, S_ASRC, {3'b0, asrc});
        exp_at(1, 1'b0, S_PCS,  {3'b0, pcs});
        exp_at(1, 1'b0, S_JALR, {3'b0, jr});
        exp_at(1, 1'b0, S_RS0,  {3'b0, rs0});
        if (depth >= 2) begin
            exp_at(2, 1'b0, S_MWM, {3'b0, mw});
            exp_at(2, 1'b0, S_RWM, {3'b0, rw});
        end
        if (depth >= 3) begin
            exp_at(3, 1'b0, S_RWW,  {3'b0, rw});
            exp_at(3, 1'b0, S_RSW,  {2'b0, rsw});
            exp_at(3, 1'b0, S_ILLW, {3'b0, ill});
        end
        tick();
        FlushE = 1'b0;
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_ADDI  = 32'hC0000093;
    localparam logic [31:0] I_SRA   = 32'h4020D1B3;
    localparam logic [31:0] I_SRAI  = 32'h4010D193;
    localparam logic [31:0] I_SLTU  = 32'h0020B1B3;
    localparam logic [31:0] I_XORI  = 32'h0040C093;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_LW    = 32'h0000A183;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_BNE   = 32'h00209063;
    localparam logic [31:0] I_BLT   = 32'h0020C063;
    localparam logic [31:0] I_B010  = 32'h0020A063;
    localparam logic [31:0] I_BGEU  = 32'h0020F063;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    initial begin
        #100000;
        $display("FAIL watchdog stamp %0d", stamp);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, asserted between edges.
        #1 rst_n = 1'b0;
        exp_at(0, 1'b1, S_ALUC, 4'h0);
        exp_at(0, 1'b1, S_ASRC, 4'h0);
        exp_at(0, 1'b1, S_PCS,  4'h0);
        exp_at(0, 1'b1, S_JALR, 4'h0);
        exp_at(0, 1'b1, S_RS0,  4'h0);
        exp_at(0, 1'b1, S_MWM,  4'h0);
        exp_at(0, 1'b1, S_RWM,  4'h0);
        exp_at(0, 1'b1, S_RSW,  4'h0);
        exp_at(0, 1'b1, S_RWW,  4'h0);
        exp_at(0, 1'b1, S_ILLW, 4'h0);
        settle();
        exp_at(1, 1'b0, S_RWW, 4'h0);
        tick();
        rst_n = 1'b1;

        //    instr   fl d  imm     aluc  as pc jr r0 mw rw rsw   ill
        issue(I_ADD,  0, 3, 3'd0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_SUB,  0, 3, 3'd0, 4'h1, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_ADDI, 0, 3, 3'd0, 4'h0, 1, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_SRA,  0, 3, 3'd0, 4'h9, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_SRAI, 0, 3, 3'd0, 4'h9, 1, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_SLTU, 0, 3, 3'd0, 4'h6, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_XORI, 0, 3, 3'd0, 4'h4, 1, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_LUI,  0, 3, 3'd4, 4'h0, 1, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_LW,   0, 3, 3'd0, 4'h0, 1, 0, 0, 1, 0, 1, 2'd1, 0);
        issue(I_SW,   0, 3, 3'd1, 4'h0, 1, 0, 0, 0, 1, 0, 2'd0, 0);

        // Branch resolution against the live ALU flags.
        flags(0, 0, 0);
        issue(I_BNE,  0, 3, 3'd2, 4'h1, 0, 1, 0, 0, 0, 0, 2'd0, 0);
        flags(1, 0, 0);
        probe(S_PCS, 4'h0);
        flags(0, 1, 0);
        issue(I_BLT,  0, 3, 3'd2, 4'h1, 0, 1, 0, 0, 0, 0, 2'd0, 0);
        flags(0, 0, 0);
        probe(S_PCS, 4'h0);
        flags(1, 1, 1);
        issue(I_B010, 0, 3, 3'd2, 4'h1, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        flags(0, 0, 1);
        issue(I_BGEU, 0, 3, 3'd2, 4'h1, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        flags(0, 0, 0);
        probe(S_PCS, 4'h1);
        flags(1, 0, 0);
        issue(I_BEQ,  0, 3, 3'd2, 4'h1, 0, 1, 0, 0, 0, 0, 2'd0, 0);
        flags(0, 0, 0);

        issue(I_JAL,  0, 3, 3'd3, 4'h0, 0, 1, 0, 0, 0, 1, 2'd2, 0);
        issue(I_JALR, 0, 3, 3'd0, 4'h0, 1, 1, 1, 0, 0, 1, 2'd2, 0);
        issue(I_ILL,  0, 3, 3'd0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0, ILL_ON);
        issue(I_ADD,  0, 3, 3'd0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd0, 0);

        // Flushed instructions become bubbles; older ones keep moving.
        issue(I_LW,   1, 3, 3'd0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        issue(I_ILL,  1, 3, 3'd0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        issue(I_SW,   1, 3, 3'd1, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        issue(I_LW,   0, 3, 3'd0, 4'h0, 1, 0, 0, 1, 0, 1, 2'd1, 0);

        // Async reset while sw sits in M.
        issue(I_SW,   0, 2, 3'd1, 4'h0, 1, 0, 0, 0, 1, 0, 2'd0, 0);
        issue(I_ADD,  0, 1, 3'd0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        rst_n = 1'b0;
        exp_at(0, 1'b1, S_MWM,  4'h0);
        exp_at(0, 1'b1, S_RWM,  4'h0);
        exp_at(0, 1'b1, S_RWW,  4'h0);
        exp_at(0, 1'b1, S_RSW,  4'h0);
        exp_at(0, 1'b1, S_ASRC, 4'h0);
        settle();
        checks++;
        if (MemWriteM !== 1'b0) begin
            errors++;
            $display("FAIL async MemWriteM got %b", MemWriteM);
        end
        checks++;
        if (RegWriteW !== 1'b0) begin
            errors++;
            $display("FAIL async RegWriteW got %b", RegWriteW);
        end
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL async PCSrcE got %b", PCSrcE);
        end
        checks++;
        if (ALUSrcE !== 1'b0) begin
            errors++;
            $display("FAIL async ALUSrcE got %b", ALUSrcE);
        end
        InstrD = I_JALR;
        exp_at(1, 1'b0, S_PCS, 4'h0);
        exp_at(1, 1'b0, S_RWW, 4'h0);
        tick();
        rst_n = 1'b1;

        // No stale controls after release.
        exp_at(1, 1'b0, S_RWW, 4'h0);
        exp_at(1, 1'b0, S_MWM, 4'h0);
        exp_at(2, 1'b0, S_RWW, 4'h0);
        issue(I_ADD,  0, 3, 3'd0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_LUI,  0, 3, 3'd4, 4'h0, 1, 0, 0, 0, 0, 1, 2'd0, 0);
        issue(I_ADD,  0, 3, 3'd0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        InstrD = I_ADD;
        tick();
        tick();
        tick();
        tick();

        foreach (q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s pending due %0d got none want %0h",
                     q[i].s.name(), q[i].due, q[i].v);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
